banco_ativos: RTL and testbench

//  Active-node bank of the path-search core; the producer side of the min-criterion classifier.
//  - Holds up to NUM_NA active nodes, each with a node address and a criterion.
//  - Drives the packed na_ativo/na_criterio vectors and the one-cycle aa_atualizar strobe.
//  - Waits for the classifier's pronto, then resolves which node address owns the returned minimum.

---
 rtl/banco_ativos.sv | 243 ++++++++++++++++++++++++
 tb/tb_banco_ativos.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_ativos.sv
// Active-node bank: holds node/criterion slots, strobes the min classifier after each
// change, then resolves which node address owns the returned minimum criterion.
module banco_ativos #(
  parameter int NUM_NA         = 8,
  parameter int ADR_WIDTH      = 8,
  parameter int CRITERIO_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ins_valid_in,
  input  logic [ADR_WIDTH-1:0]               ins_adr_in,
  input  logic [CRITERIO_WIDTH-1:0]          ins_criterio_in,
  input  logic                               rem_valid_in,
  input  logic [ADR_WIDTH-1:0]               rem_adr_in,
  output logic                               req_ready_out,
  output logic                               aa_atualizar_out,
  output logic [NUM_NA-1:0]                  na_ativo_out,
  output logic [NUM_NA*CRITERIO_WIDTH-1:0]   na_criterio_out,
  input  logic                               ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]          ca_criterio_geral_in,
  output logic                               min_valid_out,
  output logic [ADR_WIDTH-1:0]               min_adr_out,
  output logic                               full_out,
  output logic                               empty_out,
  output logic                               overflow_out
);

  localparam int SLOT_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_NA - 1);
  localparam logic [CRITERIO_WIDTH-1:0] CRIT_VAZIO = '1;

  typedef enum logic [2:0] {
    IDLE,
    BUSCA,
    GRAVA,
    ATUALIZA,
    ESPERA,
    LOCALIZA
  } estado_t;

  estado_t                   state_reg, state_next;
  logic [SLOT_W-1:0]         slot_reg, slot_next;
  logic                      op_ins_reg, op_ins_next;
  logic [ADR_WIDTH-1:0]      op_adr_reg, op_adr_next;
  logic [CRITERIO_WIDTH-1:0] op_crit_reg, op_crit_next;
  logic                      match_found_reg, match_found_next;
  logic [SLOT_W-1:0]         match_idx_reg, match_idx_next;
  logic                      free_found_reg, free_found_next;
  logic [SLOT_W-1:0]         free_idx_reg, free_idx_next;
  logic [CRITERIO_WIDTH-1:0] alvo_reg, alvo_next;
  logic                      min_valid_reg, min_valid_next;
  logic [ADR_WIDTH-1:0]      min_adr_reg, min_adr_next;
  logic                      overflow_reg, overflow_next;

  logic                      ativo_reg    [NUM_NA];
  logic [CRITERIO_WIDTH-1:0] criterio_reg [NUM_NA];
  logic [ADR_WIDTH-1:0]      adr_reg      [NUM_NA];

  // Single slot write port, driven only from GRAVA.
  logic                      wr_en;
  logic [SLOT_W-1:0]         wr_idx;
  logic                      wr_ativo;
  logic [CRITERIO_WIDTH-1:0] wr_crit;
  logic                      wr_adr_en;
  logic [ADR_WIDTH-1:0]      wr_adr;

  always_comb begin
    state_next       = state_reg;
    slot_next        = slot_reg;
    op_ins_next      = op_ins_reg;
    op_adr_next      = op_adr_reg;
    op_crit_next     = op_crit_reg;
    match_found_next = match_found_reg;
    match_idx_next   = match_idx_reg;
    free_found_next  = free_found_reg;
    free_idx_next    = free_idx_reg;
    alvo_next        = alvo_reg;
    min_valid_next   = min_valid_reg;
    min_adr_next     = min_adr_reg;
    overflow_next    = overflow_reg;
    wr_en            = 1'b0;
    wr_idx           = '0;
    wr_ativo         = 1'b0;
    wr_crit          = CRIT_VAZIO;
    wr_adr_en        = 1'b0;
    wr_adr           = '0;

    case (state_reg)
      IDLE: begin
        if (ins_valid_in || rem_valid_in) begin
          // Insert has priority; a simultaneous remove is simply not accepted.
          op_ins_next      = ins_valid_in;
          op_adr_next      = ins_valid_in ? ins_adr_in : rem_adr_in;
          op_crit_next     = ins_valid_in ? ins_criterio_in : CRIT_VAZIO;
          min_valid_next   = 1'b0;
          slot_next        = '0;
          match_found_next = 1'b0;
          free_found_next  = 1'b0;
          state_next       = BUSCA;
        end
      end

      BUSCA: begin
        if (ativo_reg[slot_reg] && (adr_reg[slot_reg] == op_adr_reg) && !match_found_reg) begin
          match_found_next = 1'b1;
          match_idx_next   = slot_reg;
        end
        if (!ativo_reg[slot_reg] && !free_found_reg) begin
          free_found_next = 1'b1;
          free_idx_next   = slot_reg;
        end
        if (slot_reg == LAST_SLOT) begin
          slot_next  = '0;
          state_next = GRAVA;
        end else begin
          slot_next = slot_reg + SLOT_W'(1);
        end
      end

      GRAVA: begin
        state_next = IDLE;
        if (op_ins_reg) begin
          if (match_found_reg) begin
            wr_en      = 1'b1;
            wr_idx     = match_idx_reg;
            wr_ativo   = 1'b1;
            wr_crit    = op_crit_reg;
            state_next = ATUALIZA;
          end else if (free_found_reg) begin
            wr_en      = 1'b1;
            wr_idx     = free_idx_reg;
            wr_ativo   = 1'b1;
            wr_crit    = op_crit_reg;
            wr_adr_en  = 1'b1;
            wr_adr     = op_adr_reg;
            state_next = ATUALIZA;
          end else begin
            overflow_next = 1'b1;
          end
        end else if (match_found_reg) begin
          wr_en      = 1'b1;
          wr_idx     = match_idx_reg;
          wr_ativo   = 1'b0;
          wr_crit    = CRIT_VAZIO;
          state_next = ATUALIZA;
        end
      end

      ATUALIZA: begin
        state_next = ESPERA;
      end

      ESPERA: begin
        if (ca_pronto_in) begin
          alvo_next  = ca_criterio_geral_in;
          slot_next  = '0;
          state_next = LOCALIZA;
        end
      end

      LOCALIZA: begin
        // Scanning upward from slot 0 gives lowest-index priority on equal criteria.
        if (ativo_reg[slot_reg] && (criterio_reg[slot_reg] == alvo_reg)) begin
          min_adr_next   = adr_reg[slot_reg];
          min_valid_next = 1'b1;
          slot_next      = '0;
          state_next     = IDLE;
        end else if (slot_reg == LAST_SLOT) begin
          min_valid_next = 1'b0;
          slot_next      = '0;
          state_next     = IDLE;
        end else begin
          slot_next = slot_reg + SLOT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      slot_reg        <= '0;
      op_ins_reg      <= 1'b0;
      op_adr_reg      <= '0;
      op_crit_reg     <= CRIT_VAZIO;
      match_found_reg <= 1'b0;
      match_idx_reg   <= '0;
      free_found_reg  <= 1'b0;
      free_idx_reg    <= '0;
      alvo_reg        <= CRIT_VAZIO;
      min_valid_reg   <= 1'b0;
      min_adr_reg     <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      slot_reg        <= slot_next;
      op_ins_reg      <= op_ins_next;
      op_adr_reg      <= op_adr_next;
      op_crit_reg     <= op_crit_next;
      match_found_reg <= match_found_next;
      match_idx_reg   <= match_idx_next;
      free_found_reg  <= free_found_next;
      free_idx_reg    <= free_idx_next;
      alvo_reg        <= alvo_next;
      min_valid_reg   <= min_valid_next;
      min_adr_reg     <= min_adr_next;
      overflow_reg    <= overflow_next;
    end
  end

  // Slot storage stays in flops: every slot is visible in parallel to the classifier.
  for (genvar gi = 0; gi < NUM_NA; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        ativo_reg[gi]    <= 1'b0;
        criterio_reg[gi] <= CRIT_VAZIO;
        adr_reg[gi]      <= '0;
      end else if (wr_en && (wr_idx == SLOT_W'(gi))) begin
        ativo_reg[gi]    <= wr_ativo;
        criterio_reg[gi] <= wr_crit;
        if (wr_adr_en) begin
          adr_reg[gi] <= wr_adr;
        end
      end
    end

    assign na_ativo_out[gi] = ativo_reg[gi];
    assign na_criterio_out[CRITERIO_WIDTH*gi +: CRITERIO_WIDTH] = criterio_reg[gi];
  end

  assign req_ready_out    = (state_reg == IDLE);
  assign aa_atualizar_out = (state_reg == ATUALIZA);
  assign min_valid_out    = min_valid_reg;
  assign min_adr_out      = min_adr_reg;
  assign overflow_out     = overflow_reg;
  assign full_out         = &na_ativo_out;
  assign empty_out        = ~|na_ativo_out;

endmodule

// File: tb/tb_banco_ativos.sv
// Randomized bench for banco_ativos: slot-level reference model plus a behavioural
// min classifier; every output is compared against the model on every cycle.
module tb_banco_ativos;

  localparam int N  = 8;
  localparam int AW = 8;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ins_valid_in;
  logic [AW-1:0]   ins_adr_in;
  logic [CW-1:0]   ins_criterio_in;
  logic            rem_valid_in;
  logic [AW-1:0]   rem_adr_in;
  logic            req_ready_out;
  logic            aa_atualizar_out;
  logic [N-1:0]    na_ativo_out;
  logic [N*CW-1:0] na_criterio_out;
  logic            ca_pronto_in;
  logic [CW-1:0]   ca_criterio_geral_in;
  logic            min_valid_out;
  logic [AW-1:0]   min_adr_out;
  logic            full_out;
  logic            empty_out;
  logic            overflow_out;

  banco_ativos #(.NUM_NA(N), .ADR_WIDTH(AW), .CRITERIO_WIDTH(CW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ins_valid_in         (ins_valid_in),
    .ins_adr_in           (ins_adr_in),
    .ins_criterio_in      (ins_criterio_in),
    .rem_valid_in         (rem_valid_in),
    .rem_adr_in           (rem_adr_in),
    .req_ready_out        (req_ready_out),
    .aa_atualizar_out     (aa_atualizar_out),
    .na_ativo_out         (na_ativo_out),
    .na_criterio_out      (na_criterio_out),
    .ca_pronto_in         (ca_pronto_in),
    .ca_criterio_geral_in (ca_criterio_geral_in),
    .min_valid_out        (min_valid_out),
    .min_adr_out          (min_adr_out),
    .full_out             (full_out),
    .empty_out            (empty_out),
    .overflow_out         (overflow_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain slot table plus expected handshake outputs.
  bit          m_act  [N];
  logic [AW-1:0] m_adr [N];
  logic [CW-1:0] m_crit[N];
  bit          exp_ready, exp_strobe, exp_overflow, exp_min_valid;
  logic [AW-1:0] exp_min_adr;
  bit          chk_en = 1'b0;
  int          acc_cyc, strobe_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [N-1:0] model_ativo();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [N*CW-1:0] model_crit();
    logic [N*CW-1:0] v;
    for (int i = 0; i < N; i++) v[CW*i +: CW] = m_crit[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i]  = 1'b0;
      m_adr[i]  = '0;
      m_crit[i] = '1;
    end
    exp_ready     = 1'b1;
    exp_strobe    = 1'b0;
    exp_overflow  = 1'b0;
    exp_min_valid = 1'b0;
    exp_min_adr   = '0;
  endtask

  task automatic model_apply(input bit ins, input logic [AW-1:0] iadr, input logic [CW-1:0] icrit,
                             input logic [AW-1:0] radr, output bit chg);
    int mi = -1;
    int fi = -1;
    logic [AW-1:0] a;
    a = ins ? iadr : radr;
    for (int i = 0; i < N; i++) begin
      if (m_act[i] && m_adr[i] == a && mi < 0) mi = i;
      if (!m_act[i] && fi < 0) fi = i;
    end
    chg = 1'b0;
    if (ins) begin
      if (mi >= 0) begin
        m_crit[mi] = icrit; chg = 1'b1;
      end else if (fi >= 0) begin
        m_act[fi] = 1'b1; m_adr[fi] = iadr; m_crit[fi] = icrit; chg = 1'b1;
      end else begin
        exp_overflow = 1'b1;
      end
    end else if (mi >= 0) begin
      m_act[mi] = 1'b0; m_crit[mi] = '1; chg = 1'b1;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] ea;
      ea = model_ativo();
      chk("req_ready", req_ready_out, exp_ready);
      chk("aa_atualizar", aa_atualizar_out, exp_strobe);
      chk("na_ativo", na_ativo_out, ea);
      chk("na_criterio", na_criterio_out, model_crit());
      chk("full", full_out, &ea);
      chk("empty", empty_out, ~|ea);
      chk("overflow", overflow_out, exp_overflow);
      chk("min_valid", min_valid_out, exp_min_valid);
      if (exp_min_valid) chk("min_adr", min_adr_out, exp_min_adr);
      if (aa_atualizar_out) strobe_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_pronto();
    ca_pronto_in         = 1'($urandom_range(0, 1));
    ca_criterio_geral_in = CW'($urandom);
  endtask

  // One full transaction, from acceptance to the classifier round trip.
  task automatic do_op(input bit ins, input bit rem, input logic [AW-1:0] iadr,
                       input logic [CW-1:0] icrit, input logic [AW-1:0] radr, input bit abort);
    bit chg, hit;
    int k, d;
    logic [CW-1:0] mn;
    ins_valid_in = ins; ins_adr_in = iadr; ins_criterio_in = icrit;
    rem_valid_in = rem; rem_adr_in = radr;
    acc_cyc = cyc;
    tick();
    ins_valid_in = 1'b0; rem_valid_in = 1'b0;
    ins_adr_in = AW'($urandom); rem_adr_in = AW'($urandom);
    exp_ready = 1'b0; exp_min_valid = 1'b0;
    for (int i = 0; i < N + 1; i++) begin
      junk_pronto();
      tick();
    end
    model_apply(ins, iadr, icrit, radr, chg);
    if (!chg) begin
      ca_pronto_in = 1'b0;
      exp_ready = 1'b1;
      $display("[TB] op ins=%0d rem=%0d iadr=%02h crit=%0d radr=%02h -> no change, ovf=%0d",
               ins, rem, iadr, icrit, radr, exp_overflow);
      return;
    end
    exp_strobe = 1'b1;
    junk_pronto();
    tick();
    exp_strobe = 1'b0;
    ca_pronto_in = 1'b0;
    if (abort) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      $display("[TB] op ins=%0d iadr=%02h crit=%0d -> reset during wait", ins, iadr, icrit);
      return;
    end
    d = $urandom_range(0, 3);
    repeat (d) tick();
    mn = '1;
    for (int i = 0; i < N; i++) if (m_crit[i] < mn) mn = m_crit[i];
    ca_pronto_in = 1'b1;
    ca_criterio_geral_in = mn;
    tick();
    ca_pronto_in = 1'b0;
    hit = 1'b0;
    k = N - 1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_act[i] && m_crit[i] == mn) begin
        hit = 1'b1; k = i;
      end
    end
    repeat (k + 1) tick();
    exp_ready = 1'b1;
    exp_min_valid = hit;
    if (hit) exp_min_adr = m_adr[k];
    $display("[TB] op ins=%0d rem=%0d iadr=%02h crit=%0d radr=%02h -> min=%0d valid=%0d adr=%02h",
             ins, rem, iadr, icrit, radr, mn, hit, exp_min_adr);
  endtask

  initial begin
    rst = 1'b1;
    ins_valid_in = 1'b0; ins_adr_in = '0; ins_criterio_in = '0;
    rem_valid_in = 1'b0; rem_adr_in = '0;
    ca_pronto_in = 1'b0; ca_criterio_geral_in = '0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_ativo", na_ativo_out, 8'h00);
    chk("reset_min_adr", min_adr_out, 8'h00);
    chk("reset_ready", req_ready_out, 1'b1);

    // Single insert: latency and first result.
    do_op(1, 0, 8'h11, 5'd9, 8'h00, 0);
    chk("t1_latency", strobe_cyc - acc_cyc, 10);
    chk("t1_ativo", na_ativo_out, 8'h01);
    chk("t1_min_adr", min_adr_out, 8'h11);
    chk("t1_min_valid", min_valid_out, 1'b1);

    // Tie on minimum goes to the lowest slot.
    do_op(1, 0, 8'h22, 5'd4, 8'h00, 0);
    do_op(1, 0, 8'h33, 5'd4, 8'h00, 0);
    chk("t2_min_adr", min_adr_out, 8'h22);

    // Decrease/increase key on an existing node.
    do_op(1, 0, 8'h22, 5'd12, 8'h00, 0);
    chk("t3_ativo", na_ativo_out, 8'h07);
    chk("t3_min_adr", min_adr_out, 8'h33);

    // Fill, overflow, absent remove.
    do_op(1, 0, 8'h44, 5'd20, 8'h00, 0);
    do_op(1, 0, 8'h55, 5'd7, 8'h00, 0);
    do_op(1, 0, 8'h66, 5'd30, 8'h00, 0);
    do_op(1, 0, 8'h77, 5'd2, 8'h00, 0);
    do_op(1, 0, 8'h88, 5'd15, 8'h00, 0);
    chk("t4_full", full_out, 1'b1);
    do_op(1, 0, 8'h99, 5'd1, 8'h00, 0);
    chk("t4_overflow", overflow_out, 1'b1);
    do_op(0, 1, 8'h00, 5'd0, 8'hFE, 0);

    // Remove slot 0, then everything.
    do_op(0, 1, 8'h00, 5'd0, 8'h11, 0);
    chk("t5_slot0_crit", na_criterio_out[4:0], 5'h1F);
    chk("t5_slot0_ativo", na_ativo_out[0], 1'b0);
    chk("t5_min_adr", min_adr_out, 8'h77);
    do_op(0, 1, 8'h00, 5'd0, 8'h22, 0);
    do_op(0, 1, 8'h00, 5'd0, 8'h33, 0);
    do_op(0, 1, 8'h00, 5'd0, 8'h44, 0);
    do_op(0, 1, 8'h00, 5'd0, 8'h55, 0);
    do_op(0, 1, 8'h00, 5'd0, 8'h66, 0);
    do_op(0, 1, 8'h00, 5'd0, 8'h77, 0);
    do_op(0, 1, 8'h00, 5'd0, 8'h88, 0);
    chk("t5_empty", empty_out, 1'b1);
    chk("t5_min_valid", min_valid_out, 1'b0);

    // Simultaneous insert and remove: insert only.
    do_op(1, 1, 8'h5A, 5'd3, 8'h5A, 0);
    chk("t6_both_ativo", na_ativo_out, 8'h01);

    // Reset while waiting for the classifier.
    do_op(1, 0, 8'h6B, 5'd8, 8'h00, 1);
    chk("t6_rst_ativo", na_ativo_out, 8'h00);
    chk("t6_rst_crit", na_criterio_out, {(N*CW){1'b1}});
    chk("t6_rst_overflow", overflow_out, 1'b0);
    chk("t6_rst_min_valid", min_valid_out, 1'b0);
    chk("t6_rst_ready", req_ready_out, 1'b1);

    // Randomized traffic over a small address pool so matches and overflow recur.
    for (int t = 0; t < 50; t++) begin
      int r;
      bit ins, rem;
      r = $urandom_range(0, 9);
      ins = (r < 6);
      rem = !ins || (r == 5);
      repeat ($urandom_range(0, 2)) begin
        junk_pronto();
        tick();
      end
      ca_pronto_in = 1'b0;
      do_op(ins, rem, 8'hA0 + 8'($urandom_range(0, 9)), CW'($urandom_range(0, 31)),
            8'hA0 + 8'($urandom_range(0, 9)), 0);
    end

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
